// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_btb
// Brief    : Direct-mapped BTB with 2-bit saturating counters, selectable
//            bimodal/gshare indexing and resolution statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int PC_W    = 10,
    parameter int INDEX_W = 4,
    parameter int HIST_W  = 4,
    parameter int GSHARE  = 0,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              update_en,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              update_taken,
    input  logic [PC_W-1:0]   update_target,
    input  logic              update_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_misses
);

    localparam int         c_ENTRIES  = 1 << INDEX_W;
    localparam int         c_TAG_W    = PC_W - INDEX_W;
    localparam logic [1:0] c_CTR_RST  = 2'd1;
    localparam logic [1:0] c_CTR_ALOC = 2'd2;
    localparam logic [1:0] c_CTR_MAX  = 2'd3;
    localparam logic [1:0] c_CTR_MIN  = 2'd0;

    logic [c_TAG_W-1:0]   r_tag    [c_ENTRIES];
    logic [PC_W-1:0]      r_target [c_ENTRIES];
    logic [1:0]           r_ctr    [c_ENTRIES];
    logic [c_ENTRIES-1:0] r_valid;
    logic [HIST_W-1:0]    r_ghr;
    logic [STAT_W-1:0]    r_branches;
    logic [STAT_W-1:0]    r_misses;

    logic [INDEX_W-1:0]   w_hist_ext;
    logic [INDEX_W-1:0]   w_lkp_idx;
    logic [INDEX_W-1:0]   w_upd_idx;
    logic [c_TAG_W-1:0]   w_lkp_tag;
    logic [c_TAG_W-1:0]   w_upd_tag;
    logic                 w_upd_hit;
    logic [1:0]           w_ctr_cur;
    logic [1:0]           w_ctr_next;

    assign w_hist_ext = INDEX_W'(r_ghr);
    assign w_lkp_tag  = lookup_pc[PC_W-1:INDEX_W];
    assign w_upd_tag  = update_pc[PC_W-1:INDEX_W];

    // Both lookup and update index with the registered ghr; the update side
    // therefore sees the history as it was before this cycle's shift.
    generate
        if (GSHARE != 0) begin : g_gshare
            assign w_lkp_idx = lookup_pc[INDEX_W-1:0] ^ w_hist_ext;
            assign w_upd_idx = update_pc[INDEX_W-1:0] ^ w_hist_ext;
        end else begin : g_bimodal
            assign w_lkp_idx = lookup_pc[INDEX_W-1:0];
            assign w_upd_idx = update_pc[INDEX_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup: combinational from registered state, no write-through.
    // ------------------------------------------------------------------
    always_comb begin
        pred_hit    = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
        pred_taken  = pred_hit && r_ctr[w_lkp_idx][1];
        pred_target = pred_hit ? r_target[w_lkp_idx] : lookup_pc + PC_W'(1);
    end

    // ------------------------------------------------------------------
    // Update: saturating counter step for a tag hit.
    // ------------------------------------------------------------------
    always_comb begin
        w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_ctr_cur  = r_ctr[w_upd_idx];
        w_ctr_next = w_ctr_cur;
        if (update_taken) begin
            if (w_ctr_cur != c_CTR_MAX) begin
                w_ctr_next = w_ctr_cur + 2'd1;
            end
        end else begin
            if (w_ctr_cur != c_CTR_MIN) begin
                w_ctr_next = w_ctr_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_RST;
            end
        end else if (update_en) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= w_ctr_next;
                if (update_taken) begin
                    r_target[w_upd_idx] <= update_target;
                end
            end else if (update_taken) begin
                // Allocation replaces whatever occupied the slot.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= update_target;
                r_ctr[w_upd_idx]    <= c_CTR_ALOC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Global history register, shifted on every resolved branch.
    // ------------------------------------------------------------------
    generate
        if (HIST_W == 1) begin : g_ghr_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (update_en) begin
                    r_ghr <= update_taken;
                end
            end
        end else begin : g_ghr_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (update_en) begin
                    r_ghr <= {r_ghr[HIST_W-2:0], update_taken};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Resolution statistics, saturating at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branches <= '0;
            r_misses   <= '0;
        end else if (update_en) begin
            if (r_branches != '1) begin
                r_branches <= r_branches + STAT_W'(1);
            end
            if (update_mispredict && (r_misses != '1)) begin
                r_misses <= r_misses + STAT_W'(1);
            end
        end
    end

    assign stat_branches = r_branches;
    assign stat_misses   = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_btb
// Brief    : Directed self-checking bench for bimodal, gshare and narrow-stat
//            configurations of branch_predictor_btb driven from one stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] lookup_pc;
    logic       update_en;
    logic [9:0] update_pc;
    logic       update_taken;
    logic [9:0] update_target;
    logic       update_mispredict;

    logic        bi_hit, bi_taken;
    logic [9:0]  bi_target;
    logic [15:0] bi_br, bi_ms;
    logic        gs_hit, gs_taken;
    logic [9:0]  gs_target;
    logic [15:0] gs_br, gs_ms;
    logic        st_hit, st_taken;
    logic [9:0]  st_target;
    logic [3:0]  st_br, st_ms;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor_btb #(.PC_W(10), .INDEX_W(4), .HIST_W(4), .GSHARE(0), .STAT_W(16)) dut_bi (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(bi_hit), .pred_taken(bi_taken), .pred_target(bi_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .stat_branches(bi_br), .stat_misses(bi_ms)
    );

    branch_predictor_btb #(.PC_W(10), .INDEX_W(4), .HIST_W(4), .GSHARE(1), .STAT_W(16)) dut_gs (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(gs_hit), .pred_taken(gs_taken), .pred_target(gs_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .stat_branches(gs_br), .stat_misses(gs_ms)
    );

    branch_predictor_btb #(.PC_W(10), .INDEX_W(4), .HIST_W(4), .GSHARE(0), .STAT_W(4)) dut_st (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(st_hit), .pred_taken(st_taken), .pred_target(st_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .stat_branches(st_br), .stat_misses(st_ms)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [9:0] pc, input logic tk, input logic [9:0] tgt, input logic mp);
        update_en         = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_mispredict = mp;
        step();
        update_en         = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        update_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        lookup_pc         = '0;
        update_en         = 1'b0;
        update_pc         = '0;
        update_taken      = 1'b0;
        update_target     = '0;
        update_mispredict = 1'b0;
        do_reset();

        // Post-reset state
        lookup_pc = 10'h020;
        #1;
        check("rst_hit",    bi_hit,    0);
        check("rst_taken",  bi_taken,  0);
        check("rst_target", bi_target, 10'h021);
        check("rst_br",     bi_br,     0);
        check("rst_ms",     bi_ms,     0);

        // Bimodal allocate, then same-index different-tag miss
        upd(10'h012, 1'b1, 10'h080, 1'b0);
        lookup_pc = 10'h012;
        #1;
        check("alloc_hit",    bi_hit,    1);
        check("alloc_taken",  bi_taken,  1);
        check("alloc_target", bi_target, 10'h080);
        lookup_pc = 10'h022;
        #1;
        check("alias_hit",    bi_hit,    0);
        check("alias_target", bi_target, 10'h023);

        // Saturate at 3, one NT leaves weak-taken
        for (int i = 0; i < 4; i++) upd(10'h012, 1'b1, 10'h080, 1'b0);
        upd(10'h012, 1'b0, 10'h000, 1'b0);
        lookup_pc = 10'h012;
        #1;
        check("sat_w_taken", bi_taken, 1);
        upd(10'h012, 1'b0, 10'h000, 1'b0);
        #1;
        check("weak_nt_taken", bi_taken, 0);
        upd(10'h012, 1'b0, 10'h000, 1'b0);
        #1;
        check("strong_nt_hit",    bi_hit,    1);
        check("strong_nt_taken",  bi_taken,  0);
        check("strong_nt_target", bi_target, 10'h080);
        // Counter at 0 must not wrap: one taken step lands on weak-NT
        upd(10'h012, 1'b1, 10'h080, 1'b0);
        #1;
        check("no_wrap_taken", bi_taken, 0);
        check("br_count_9", bi_br, 9);

        // Same-cycle lookup sees pre-update state
        lookup_pc         = 10'h044;
        update_en         = 1'b1;
        update_pc         = 10'h044;
        update_taken      = 1'b1;
        update_target     = 10'h100;
        update_mispredict = 1'b1;
        #1;
        check("bypass_hit", bi_hit, 0);
        step();
        update_en         = 1'b0;
        update_mispredict = 1'b0;
        check("next_cycle_hit",    bi_hit,    1);
        check("next_cycle_target", bi_target, 10'h100);

        // Miss not-taken: no allocation, count still advances
        upd(10'h033, 1'b0, 10'h155, 1'b0);
        lookup_pc = 10'h033;
        #1;
        check("miss_nt_hit", bi_hit, 0);
        check("br_count_11", bi_br, 11);
        check("ms_count_1",  bi_ms, 1);

        // mispredict ignored without update_en
        update_mispredict = 1'b1;
        step();
        update_mispredict = 1'b0;
        check("ms_no_en", bi_ms, 1);

        // Gshare: T,T,NT,T -> ghr 1101; last allocation lands at 0xE^0x6=0x8
        do_reset();
        upd(10'h00E, 1'b1, 10'h100, 1'b0);
        upd(10'h00E, 1'b1, 10'h100, 1'b0);
        upd(10'h00E, 1'b0, 10'h100, 1'b0);
        upd(10'h00E, 1'b1, 10'h155, 1'b0);
        lookup_pc = 10'h005;
        #1;
        check("gs_hit",    gs_hit,    1);
        check("gs_taken",  gs_taken,  1);
        check("gs_target", gs_target, 10'h155);
        check("bi_5_hit",  bi_hit,    0);
        lookup_pc = 10'h00E;
        #1;
        check("gs_e_hit",    gs_hit,    0);
        check("gs_e_target", gs_target, 10'h00F);
        check("bi_e_hit",    bi_hit,    1);
        check("gs_br",       gs_br,     4);

        // Narrow statistics saturate; reset beats a concurrent update
        do_reset();
        for (int i = 0; i < 20; i++) upd(10'h001, 1'b1, 10'h200, 1'b1);
        lookup_pc = 10'h001;
        #1;
        check("st_br_sat", st_br, 4'hF);
        check("st_ms_sat", st_ms, 4'hF);
        check("bi_br_20",  bi_br, 20);
        check("bi_ms_20",  bi_ms, 20);
        check("pre_rst_hit", bi_hit, 1);
        rst               = 1'b1;
        update_en         = 1'b1;
        update_pc         = 10'h001;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        step();
        rst               = 1'b0;
        update_en         = 1'b0;
        update_mispredict = 1'b0;
        #1;
        check("rst_upd_st_br", st_br,     0);
        check("rst_upd_st_ms", st_ms,     0);
        check("rst_upd_hit",   bi_hit,    0);
        check("rst_upd_tgt",   bi_target, 10'h002);
        check("rst_upd_br",    bi_br,     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised successor to the single-mode branch predictor in the pipelined RAT CPU.
- Combines a direct-mapped branch target buffer (tag, target, valid) with a table of 2-bit saturating counters.
- Lookup is combinational for the PC currently on the instruction-memory line (fetch stage).
- Update is registered from the execute stage, after the branch calculator resolves direction.
- Adds selectable bimodal or gshare indexing and resolution statistics counters.

Parameters:
PC_W, 10, width of program-counter and target addresses
INDEX_W, 4, log2 of table entries (16 entries by default); 1 <= INDEX_W < PC_W
HIST_W, 4, global history register width; 0 < HIST_W <= INDEX_W
GSHARE, 0, 0 = bimodal index (pc[INDEX_W-1:0]); 1 = gshare index (pc[INDEX_W-1:0] XOR zero-extended ghr)
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
lookup_pc  in  PC_W  fetch-stage PC to predict
pred_hit  out  1  valid BTB entry whose tag matches lookup_pc
pred_taken  out  1  pred_hit AND counter[1]
pred_target  out  PC_W  stored target when pred_hit, else lookup_pc+1 (mod 2^PC_W)
update_en  in  1  resolved branch present in execute stage this cycle
update_pc  in  PC_W  PC of resolved branch
update_taken  in  1  actual outcome
update_target  in  PC_W  actual branch destination
update_mispredict  in  1  branch calculator miss flag for this branch
stat_branches  out  STAT_W  resolved branch count
stat_misses  out  STAT_W  mispredict count

Behaviour:
- Index and tag:
  - Tag = pc[PC_W-1:INDEX_W].
  - Lookup index uses the current ghr. Update index uses ghr_at_update, the ghr value before this cycle's shift.
  - GSHARE=1 accepts aliasing between lookup and update indices caused by history drift; no history checkpointing.
- Lookup:
  - Purely combinational from lookup_pc and registered table state.
  - An update in the same cycle is not visible until the next cycle; no write-through bypass.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Saturates at 0 and 3, no wrap.
- Update rules (rising edge, update_en=1):
  - Tag hit: counter +1 if taken, -1 if not taken. Target overwritten with update_target if taken.
  - Miss and taken: allocate the entry (valid=1, tag, target); counter := 2. Any previous entry is replaced.
  - Miss and not taken: no table change.
- Global history:
  - ghr := {ghr[HIST_W-2:0], update_taken} on every update_en. For HIST_W=1, ghr := update_taken.
  - Held otherwise. Updated under GSHARE=0 as well, but unused for indexing.
- Statistics:
  - stat_branches +1 on every update_en.
  - stat_misses +1 when update_en AND update_mispredict.
  - Both saturate at all-ones. update_mispredict is ignored when update_en=0.
- Reset:
  - All valid bits 0, all counters 1, all targets and tags 0, ghr 0, stats 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+1, stats 0.
  - Reset asserted together with update_en: reset wins, no update applied.
  - Reset mid-operation discards all learned state.
- Latency: prediction is 0 cycles after lookup_pc. An update affects a lookup from the next cycle.

Test Plan:
1. Post-reset lookup_pc=0x020 -> pred_hit=0, pred_taken=0, pred_target=0x021, stats=0.
2. Bimodal allocate: update pc=0x012 taken target=0x080 -> next cycle lookup 0x012 gives hit=1, taken=1, target=0x080. Lookup 0x022 (same index, different tag) -> hit=0.
3. Saturation: four taken updates to 0x012 then one not-taken -> counter 2, still predicted taken. Two more not-taken -> counter 0, predicted not-taken with hit=1, target=0x080 retained.
4. Miss not-taken: update pc=0x033 not-taken on empty entry -> no allocation; stat_branches +1. Same-cycle lookup of a just-updated PC returns pre-update state.
5. GSHARE=1, HIST_W=4: taken,taken,not-taken,taken updates from reset -> ghr=4'b1101. Lookup 0x005 uses index 0x5^0xD=0x8.
6. Stats: STAT_W=4, 20 updates with mispredict=1 -> both counters hold 0xF. rst with update_en high -> stats 0, table cleared.
